// File: rtl/cla_div_clk.sv
// Registered 32-bit unsigned restoring divider.
// One quotient bit per clock; the subtract step runs through cla32.

module cla4_sum (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [3:0] s
);

  logic [3:0] c;

  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end

endmodule

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] p;
  logic [31:0] g;
  logic [7:0]  gp;
  logic [7:0]  gg;
  logic [8:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2]
               & p[4*i+1] & g[4*i]);
    end
  end

  // Group carries expanded from ci only, no chain through gc.
  always_comb begin
    logic acc;
    gc = '0;
    for (int k = 0; k <= 8; k++) begin
      acc = ci;
      for (int j = 0; j < k; j++) begin
        acc = gg[j] | (gp[j] & acc);
      end
      gc[k] = acc;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_blk
    cla4_sum u_sum (
      .p  (p[4*i +: 4]),
      .g  (g[4*i +: 4]),
      .ci (gc[i]),
      .s  (s[4*i +: 4])
    );
  end

  assign co = gc[8];

endmodule

module cla_div_clk (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] d_q, d_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  logic [31:0] s_w;
  logic [31:0] nd_w;
  logic [31:0] t_w;
  logic        co_w;
  logic        ok_w;

  assign s_w  = {r_q[30:0], q_q[31]};
  assign nd_w = ~d_q;

  cla32 u_sub (
    .a  (s_w),
    .b  (nd_w),
    .ci (1'b1),
    .s  (t_w),
    .co (co_w)
  );

  // r_q[31] set means the 33-bit shifted value exceeds any divisor.
  assign ok_w = r_q[31] | co_w;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        r_d   = ok_w ? t_w : s_w;
        q_d   = {q_q[30:0], ok_w};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
